// File: rtl/key_debounce_arbiter.sv
// Shared-timer debounce for a bank of active-low keys: falling edges queue as
// requests, are served round-robin through one settle counter, and confirmed presses pulse.
module key_debounce_arbiter #(
   parameter int                NUM_KEYS   = 4,
   parameter int                IDX_W      = 2,
   parameter int                CNT_W      = 18,
   parameter logic [CNT_W-1:0]  SETTLE_MAX = 18'h3FFFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic                busy,
   output logic [IDX_W-1:0]    active_idx
);

   localparam int unsigned NK = NUM_KEYS;

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

   state_t              r_state, w_state_nxt;
   logic [NUM_KEYS-1:0] r_key_s1, r_key_s2, r_key_prev;
   logic [NUM_KEYS-1:0] r_pend;
   logic [NUM_KEYS-1:0] r_key_pulse;
   logic [IDX_W-1:0]    r_last_grant;
   logic [IDX_W-1:0]    r_active_idx;
   logic [CNT_W-1:0]    r_cnt;

   logic [NUM_KEYS-1:0] w_fall_det;
   logic [NUM_KEYS-1:0] w_act_oh;
   logic [NUM_KEYS-1:0] w_pick_oh;
   logic [NUM_KEYS-1:0] w_pend_set;
   logic [IDX_W-1:0]    w_pick;
   logic                w_pick_vld;
   logic                w_act_fall;
   logic                w_act_low;
   logic                w_grant, w_cnt_clr, w_cnt_inc, w_fire, w_done;

   assign w_fall_det = r_key_prev & ~r_key_s2;
   assign w_act_oh   = NUM_KEYS'(1) << r_active_idx;
   assign w_pick_oh  = NUM_KEYS'(1) << w_pick;
   assign w_act_fall = |(w_fall_det & w_act_oh);
   assign w_act_low  = ~|(r_key_s2 & w_act_oh);
   // A bounce on the key being timed restarts its window instead of re-queuing it.
   assign w_pend_set = w_fall_det & ~((r_state == SETTLE) ? w_act_oh : '0);

   // First pending key after last_grant, wrapping modulo NUM_KEYS.
   always_comb begin
      int unsigned         v_idx;
      logic [NUM_KEYS-1:0] v_mask;
      w_pick     = '0;
      w_pick_vld = 1'b0;
      v_idx      = 0;
      v_mask     = '0;
      for (int unsigned k = 1; k <= NK; k++) begin
         v_idx  = (32'(r_last_grant) + k) % NK;
         v_mask = NUM_KEYS'(1) << v_idx;
         if (!w_pick_vld && |(r_pend & v_mask)) begin
            w_pick     = IDX_W'(v_idx);
            w_pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_fire      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pick_vld) begin
               w_grant     = 1'b1;
               w_state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (w_act_fall) begin
               w_cnt_clr = 1'b1;
            end else if (r_cnt == SETTLE_MAX) begin
               w_state_nxt = CHECK;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         CHECK: begin
            w_done      = 1'b1;
            w_fire      = w_act_low;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_s1     <= '1;
         r_key_s2     <= '1;
         r_key_prev   <= '1;
         r_pend       <= '0;
         r_key_pulse  <= '0;
         r_last_grant <= IDX_W'(NUM_KEYS - 1);
         r_active_idx <= '0;
         r_cnt        <= '0;
      end else begin
         r_key_s1    <= key;
         r_key_s2    <= r_key_s1;
         r_key_prev  <= r_key_s2;
         // Set is applied after clear so a same-cycle fall on the granted key survives.
         r_pend      <= (r_pend & ~(w_grant ? w_pick_oh : '0)) | w_pend_set;
         r_key_pulse <= w_fire ? w_act_oh : '0;
         if (w_grant) begin
            r_active_idx <= w_pick;
         end
         if (w_grant || w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_done) begin
            r_last_grant <= r_active_idx;
         end
      end
   end

   assign key_pulse  = r_key_pulse;
   assign busy       = (r_state != IDLE);
   assign active_idx = r_active_idx;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Directed bench for key_debounce_arbiter with a 15-cycle settle window;
// cycle 0 is the cycle in which the synchronised fall is first visible.
module tb_key_debounce_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'hF;
   logic [3:0] key_pulse;
   logic       busy;
   logic [1:0] active_idx;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   key_debounce_arbiter #(
      .NUM_KEYS  (4),
      .IDX_W     (2),
      .CNT_W     (18),
      .SETTLE_MAX(18'd15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_pulse (key_pulse),
      .busy      (busy),
      .active_idx(active_idx)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic idle_gap();
      key = 4'hF;
      repeat (5) tick();
   endtask

   // Steps up to cycle 'last', checking key_pulse against up to two expected
   // pulses and busy against up to two inclusive windows.
   task automatic watch(input int last,
                        input int pc0, input logic [3:0] pv0,
                        input int pc1, input logic [3:0] pv1,
                        input int blo0, input int bhi0,
                        input int blo1, input int bhi1);
      logic [3:0] exp_p;
      logic       exp_b;
      while (cyc < last) begin
         tick();
         exp_p = (cyc == pc0) ? pv0 : (cyc == pc1) ? pv1 : 4'h0;
         exp_b = ((cyc >= blo0) && (cyc <= bhi0)) || ((cyc >= blo1) && (cyc <= bhi1));
         check_val("key_pulse", 32'(key_pulse), 32'(exp_p));
         check_val("busy", 32'(busy), 32'(exp_b));
      end
   endtask

   initial begin
      do_reset();
      check_val("rst_pulse", 32'(key_pulse), 32'h0);
      check_val("rst_busy", 32'(busy), 32'h0);
      check_val("rst_idx", 32'(active_idx), 32'h0);
      check_val("rst_pend", 32'(dut.r_pend), 32'h0);
      repeat (3) tick();

      // Clean press on key 1.
      key = 4'b1101; cyc = -2;
      watch(24, 19, 4'b0010, -100, 4'h0, 2, 18, 1, 0);
      check_val("clean_idx", 32'(active_idx), 32'd1);
      idle_gap();

      // Bounce on key 1: released at 4, pressed again at 6 -> fall_det at 8.
      key = 4'b1101; cyc = -2;
      watch(4, 26, 4'b0010, -100, 4'h0, 2, 25, 1, 0);
      key = 4'b1111;
      watch(6, 26, 4'b0010, -100, 4'h0, 2, 25, 1, 0);
      key = 4'b1101;
      watch(9, 26, 4'b0010, -100, 4'h0, 2, 25, 1, 0);
      check_val("bounce_pend", 32'(dut.r_pend), 32'h0);
      watch(30, 26, 4'b0010, -100, 4'h0, 2, 25, 1, 0);
      check_val("bounce_pend_end", 32'(dut.r_pend), 32'h0);
      idle_gap();

      // Glitch on key 2: released early, CHECK sees it high.
      key = 4'b1011; cyc = -2;
      watch(5, -100, 4'h0, -100, 4'h0, 2, 18, 1, 0);
      key = 4'b1111;
      watch(24, -100, 4'h0, -100, 4'h0, 2, 18, 1, 0);
      check_val("glitch_idx", 32'(active_idx), 32'd2);
      idle_gap();

      // Simultaneous press of keys 0 and 2 after reset.
      do_reset();
      repeat (3) tick();
      key = 4'b1010; cyc = -2;
      watch(10, 19, 4'b0001, 37, 4'b0100, 2, 18, 20, 36);
      check_val("simul_idx0", 32'(active_idx), 32'd0);
      watch(40, 19, 4'b0001, 37, 4'b0100, 2, 18, 20, 36);
      check_val("simul_idx2", 32'(active_idx), 32'd2);
      idle_gap();

      // Round-robin: last served was key 2, so key 3 precedes key 1.
      key = 4'b0101; cyc = -2;
      watch(10, 19, 4'b1000, 37, 4'b0010, 2, 18, 20, 36);
      check_val("rr_idx3", 32'(active_idx), 32'd3);
      watch(40, 19, 4'b1000, 37, 4'b0010, 2, 18, 20, 36);
      check_val("rr_idx1", 32'(active_idx), 32'd1);
      idle_gap();

      // Reset in the middle of a key 0 settle window.
      key = 4'b1110; cyc = -2;
      watch(10, -100, 4'h0, -100, 4'h0, 2, 40, 1, 0);
      rst = 1'b1;
      key = 4'b1111;
      tick();
      check_val("mid_rst_busy", 32'(busy), 32'h0);
      check_val("mid_rst_pend", 32'(dut.r_pend), 32'h0);
      check_val("mid_rst_pulse", 32'(key_pulse), 32'h0);
      check_val("mid_rst_idx", 32'(active_idx), 32'h0);
      rst = 1'b0;
      watch(50, -100, 4'h0, -100, 4'h0, 1, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_arbiter.md
# key_debounce_arbiter

Shared-timer debounce controller for the board's push-button bank. Up to NUM_KEYS raw active-low keys share a single settle counter. Falling edges are queued as pending requests and granted the timer in round-robin order. After the settle window the granted key is re-sampled, and a one-cycle pulse is emitted on its `key_pulse` bit if it is still pressed. It sits between the board key pins and the CPU control/step logic.

## Interface
- `NUM_KEYS`, 4: number of raw keys.
- `IDX_W`, 2: width of the key index; must satisfy 2^IDX_W >= NUM_KEYS.
- `CNT_W`, 18: settle counter width.
- `SETTLE_MAX`, 18'h3FFFF: terminal count of the settle window.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `key` input NUM_KEYS: raw key pins, active-low, idle high, asynchronous to `clk`.
- `key_pulse` output NUM_KEYS: registered one-cycle pulse per confirmed press; at most one bit high per cycle.
- `busy` output 1: high while the settle timer is owned by a key (state != IDLE).
- `active_idx` output IDX_W: index of the key currently or last granted the timer.

## Operation
- **Synchronizer**
  - Each key passes through a two-flop synchronizer `key_s1` -> `key_s2`, plus a history flop `key_prev`.
  - All three reset to all ones.
  - `fall_det[i] = key_prev[i] & ~key_s2[i]` (combinational).
- **Pending register `pend[NUM_KEYS]`**
  - `pend[i]` is set when `fall_det[i]` is high.
  - `pend[i]` is cleared when key i is granted.
  - Exception: while key i is active in SETTLE, its `fall_det` does not set `pend`; it restarts the counter instead.
  - Set and clear in the same cycle for the same key: set wins.
- **Round-robin pointer `last_grant`**
  - Resets to NUM_KEYS-1, so key 0 has first priority.
  - Search starts at `last_grant+1` and wraps modulo NUM_KEYS.
- **FSM states: IDLE, SETTLE, CHECK**
  - IDLE: if `pend` is nonzero, pick the first set bit in round-robin order. Then `active_idx` <= pick, `pend[pick]` <= 0, `cnt` <= 0, go to SETTLE. Otherwise stay in IDLE.
  - SETTLE, priority order:
    1. `fall_det[active_idx]` high: `cnt` <= 0 (bounce restarts the window).
    2. Else `cnt == SETTLE_MAX`: go to CHECK.
    3. Else `cnt` <= `cnt+1`.
  - CHECK: if `key_s2[active_idx] == 0`, `key_pulse` <= one-hot(`active_idx`); otherwise no pulse. In both cases `last_grant` <= `active_idx` and go to IDLE.
- **Outputs**
  - `key_pulse` is cleared every cycle unless written by CHECK.
  - `busy = (state != IDLE)`.
- **Width rules**
  - `cnt` is CNT_W bits and never wraps, because the terminal compare precedes the increment.
  - Round-robin index arithmetic is modulo NUM_KEYS, not 2^IDX_W.
- **Reset values** (on `rst`, regardless of state):
  - state = IDLE, `cnt` = 0, `pend` = 0, `key_pulse` = 0, `busy` = 0, `active_idx` = 0, `last_grant` = NUM_KEYS-1.
  - A pending pulse is discarded.
  - A key held low through reset is detected as a new fall once the synchronizer flushes.

## Timing
- Cycle 0 is the first cycle in which `fall_det[i]` is high with the FSM idle and no other requests.
  - Cycle 1: IDLE grants key i.
  - Cycles 2..2+SETTLE_MAX: SETTLE, with `cnt` = 0..SETTLE_MAX.
  - Cycle 3+SETTLE_MAX: CHECK.
  - Cycle 4+SETTLE_MAX: `key_pulse[i]` high for exactly one cycle, state already IDLE.
- Raw pin to `fall_det` adds 2 cycles of synchronizer latency.
- Bounce: if the last `fall_det` on the active key occurs in cycle k during SETTLE, the pulse occurs at cycle k+SETTLE_MAX+3.
- Back-to-back service: the next grant happens in the same cycle the previous pulse is visible. Per-key service time is therefore SETTLE_MAX+3 cycles.
- `busy` is high from cycle 2 through cycle 3+SETTLE_MAX inclusive.

## Test plan
Use SETTLE_MAX=15, NUM_KEYS=4, CNT_W=18.
- **Clean press:** `key[1]` goes low and stays low, with `fall_det[1]` at cycle 0 -> `key_pulse` = 4'b0010 in cycle 19 only; `busy` high in cycles 2–18; `active_idx` = 1.
- **Bounce:** `key[1]` goes low, high at cycle 6, and low again with `fall_det` at cycle 8 -> `cnt` restarts; a single pulse at cycle 26; `pend[1]` stays 0.
- **Glitch:** `key[2]` goes low at cycle 0 and is released before cycle 10 -> CHECK sees high; no pulse; `busy` drops at cycle 19.
- **Simultaneous press:** `key[0]` and `key[2]` fall in the same cycle after reset -> `key_pulse[0]` at cycle 19, `key_pulse[2]` at cycle 37, never overlapping.
- **Round-robin:** after key 2 is served, keys 1 and 3 are both pending -> key 3 is granted first, then key 1.
- **Reset mid-SETTLE:** `rst` asserted at cycle 10 of a key-0 press -> `busy` = 0 and `pend` = 0 on the next cycle; no pulse ever appears for that press.
